// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Two-requester arbiter and sequencer in front of a 32x8 synchronous-read
//   memory. Port A is the instruction-fetch side, port B is the load/store side.
//   One access is granted at a time. Ties go to the port that was not served
//   last (round-robin). The memory pins are driven from registers. The memory's
//   data_out arrives one cycle late; it is captured and returned to the owning
//   port together with a single-cycle valid pulse.
//
//   Sequence of one access:
//     IDLE   -> arbitration on the edge, winner latched
//     ACCESS -> gnt pulse, mem_rd or mem_wr high for exactly one cycle
//     RESP   -> (reads only) mem_data_out valid, captured on the closing edge
//   Read latency:  req sampled at edge N, gnt in cycle N+1, rvalid in cycle N+3.
//   Write throughput is one per 2 cycles. Read throughput is one per 3 cycles.
//
// Optional feature (compile-time macro MEM_ARB_WRPROT_EN):
//   A port-B write to an address <= PROT_TOP is still granted, but mem_wr is
//   held low and b_err pulses alongside b_gnt. Without the macro b_err is tied
//   low and PROT_TOP has no effect.
//
// Parameters:
//   ADDR_W    memory address width
//   DATA_W    memory data width
//   PROT_TOP  highest write-protected address for port B (macro builds only)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   a_req/b_req   access request, held until the matching gnt is seen
//   a_we/b_we     1 = write, 0 = read
//   a_addr/b_addr access address
//   a_wdata/b_wdata  write data
//   a_gnt/b_gnt   one-cycle pulse: request accepted
//   a_rvalid/b_rvalid  one-cycle pulse: rdata valid
//   a_rdata/b_rdata    read data, held until the port's next read returns
//   b_err         one-cycle pulse: port-B write dropped by protection
//   mem_addr, mem_data_in, mem_rd, mem_wr  registered memory controls
//   mem_data_out  memory read data (valid the cycle after mem_rd)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int PROT_TOP = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Control state
  state_t state_q, state_d;
  logic   last_b_q, last_b_d;    // 1 = port B was served most recently
  logic   owner_b_q, owner_b_d;  // 1 = current access belongs to port B
  logic   we_q, we_d;            // current access is a write

  // Registered outputs
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              b_err_d;

  // Arbitration result, meaningful only in IDLE with a request present
  logic              win_b;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              wr_blocked;

  // B wins when it is the only requester, or on a tie when A went last.
  assign win_b     = b_req && (!a_req || !last_b_q);
  assign win_we    = win_b ? b_we    : a_we;
  assign win_addr  = win_b ? b_addr  : a_addr;
  assign win_wdata = win_b ? b_wdata : a_wdata;

`ifdef MEM_ARB_WRPROT_EN
  localparam logic [ADDR_W-1:0] PROT_TOP_A = ADDR_W'(PROT_TOP);

  // Only port-B writes into the low region are suppressed.
  assign wr_blocked = win_b && win_we && (win_addr <= PROT_TOP_A);
`else
  assign wr_blocked = 1'b0;

  // PROT_TOP only matters when protection is compiled in.
  logic unused_prot_top;
  assign unused_prot_top = (PROT_TOP < 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    last_b_d      = last_b_q;
    owner_b_d     = owner_b_q;
    we_d          = we_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    // Pulses default low so each is high for a single cycle only.
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    a_rvalid_d    = 1'b0;
    b_rvalid_d    = 1'b0;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    b_err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_b_d     = win_b;
          last_b_d      = win_b;
          we_d          = win_we;
          mem_addr_d    = win_addr;
          mem_data_in_d = win_wdata;
          mem_rd_d      = ~win_we;
          mem_wr_d      = win_we && !wr_blocked;
          b_err_d       = wr_blocked;
          a_gnt_d       = ~win_b;
          b_gnt_d       = win_b;
          state_d       = ACCESS;
        end
      end

      ACCESS: begin
        // Writes complete on this edge; reads wait one cycle for data_out.
        state_d = we_q ? IDLE : RESP;
      end

      RESP: begin
        if (owner_b_q) begin
          b_rdata_d  = mem_data_out;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = mem_data_out;
          a_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. Every output is registered and cleared by reset, so an
  // access in flight is simply abandoned.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_b_q      <= 1'b1;  // A wins the first tie after reset
      owner_b_q     <= 1'b0;
      we_q          <= 1'b0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      owner_b_q     <= owner_b_d;
      we_q          <= we_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
    end
  end

`ifdef MEM_ARB_WRPROT_EN
  logic b_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_err_q <= 1'b0;
    end else begin
      b_err_q <= b_err_d;
    end
  end

  assign b_err = b_err_q;
`else
  logic unused_b_err;
  assign unused_b_err = b_err_d;
  assign b_err        = 1'b0;
`endif

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 32x8 synchronous-read memory.
- Port A is the CPU instruction-fetch side. Port B is the CPU data / load-store side.
- Grants one access at a time using round-robin priority, and drives the memory's addr/data_in/rd/wr pins from registers.
- Captures the memory's one-cycle-late data_out and returns it to the owning requester with a valid pulse.

Parameters:
- ADDR_W, 5, memory address width (32 entries).
- DATA_W, 8, memory data width.
- PROT_TOP, 15, highest write-protected address. Used only when MEM_ARB_WRPROT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a_req  input  1  port A access request; held high until a_gnt is seen.
- a_we  input  1  port A write (1) / read (0).
- a_addr  input  ADDR_W  port A address.
- a_wdata  input  DATA_W  port A write data.
- a_gnt  output  1  one-cycle pulse: port A request accepted.
- a_rvalid  output  1  one-cycle pulse: a_rdata valid.
- a_rdata  output  DATA_W  port A read data; holds until the next A read.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B.
- b_err  output  1  one-cycle pulse: B write dropped by protection. Tied 0 without the macro.
- mem_addr  output  ADDR_W  to memory addr.
- mem_data_in  output  DATA_W  to memory data_in.
- mem_rd  output  1  to memory rd.
- mem_wr  output  1  to memory wr.
- mem_data_out  input  DATA_W  from memory data_out.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - All outputs go to 0.
  - State goes to IDLE.
  - Round-robin pointer last_b=1, so port A wins the first tie.
- Every output is registered.
- States: IDLE, ACCESS, RESP.
- IDLE: at a clock edge with any req high, arbitrate:
  - Only one port requesting: that port wins.
  - Both requesting: the port not served last wins.
  - On a win, latch the winner's addr, wdata, we and owner; set that port's gnt<=1; set mem_addr/mem_data_in; set mem_rd<=~we and mem_wr<=we; update last_b; go to ACCESS.
  - No req high: stay in IDLE with mem_rd and mem_wr at 0.
- ACCESS: lasts exactly one cycle, with gnt, mem_rd or mem_wr high. At its closing edge:
  - gnt, mem_rd and mem_wr all go to 0.
  - Read: go to RESP.
  - Write: go to IDLE.
- RESP: mem_data_out is valid in this cycle. At its closing edge:
  - The owner's rdata<=mem_data_out and the owner's rvalid<=1.
  - Go to IDLE.
  - rvalid is high for the following single cycle.
- Timing:
  - Read latency: req sampled at edge N, gnt high in cycle N+1, rvalid/rdata high in cycle N+3.
  - Read throughput: one read per 3 cycles.
  - Write throughput: one write per 2 cycles.
  - A new request can be sampled in the same cycle that rvalid is high.
- Requester contract:
  - Keep req/we/addr/wdata stable until gnt is seen.
  - Drop req at or before the edge that ends the gnt cycle.
  - The arbiter ignores req outside IDLE, so a req held during ACCESS/RESP is not double-served.
- Simultaneous requests held continuously: grants strictly alternate A, B, A, B…
- Same port requesting repeatedly with the other idle: that port is served every slot.
- a_rdata/b_rdata change only on their own port's rvalid. The other port's rdata is untouched.
- Reset mid-operation: an in-flight access is abandoned. No gnt or rvalid follows, and mem_rd/mem_wr go low at that edge.

Optional Feature:
- Macro: MEM_ARB_WRPROT_EN.
- Defined:
  - A port-B write with addr <= PROT_TOP is still granted (b_gnt pulse, ACCESS cycle).
  - mem_wr stays 0 during that ACCESS cycle.
  - b_err pulses high in the same cycle as b_gnt.
  - Port-A writes and all reads are never blocked.
- Undefined: no protection logic, PROT_TOP unused, b_err constant 0.

Test Plan:
- Reset: hold rst for 2 cycles with a_req=b_req=1 -> all outputs 0, no gnt; after release, a_gnt is the first grant.
- Single read: memory preloaded mem[3]=8'hA5; a_req, a_we=0, a_addr=3 sampled at edge N -> a_gnt, mem_rd=1, mem_addr=3 in cycle N+1; a_rvalid=1, a_rdata=8'hA5 in N+3; b_rvalid stays 0.
- Write then read back: b_we=1, b_addr=20, b_wdata=8'h3C -> mem_wr=1 with mem_data_in=8'h3C for exactly one cycle; then a B read of address 20 -> b_rdata=8'h3C; a_rdata unchanged.
- Contention: a_req and b_req held high for 4 grants -> grant order A, B, A, B; each read returns its own port's data on its own rvalid.
- Reset during RESP of an A read -> no a_rvalid; state IDLE; the next tie is won by A.
- (MEM_ARB_WRPROT_EN, PROT_TOP=15) B write to addr 7 -> b_gnt and b_err pulse, mem_wr stays 0, mem[7] unchanged. B write to addr 16 -> mem_wr=1, b_err=0. A write to addr 7 -> performed.
